snake_body_ctrl: RTL

Sequencer for the snake body store that the location-check logic reads. Owns the head and body coordinate array and the current length. On each move strobe it advances the snake one cell, applies pending growth and checks walls. It then scans the body for self-collision one segment per clock and reports done or dead to the game FSM.

---
 rtl/snake_body_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/snake_body_ctrl.sv
// Snake body store and move sequencer: advances the snake on a move strobe, then
// scans the body for self-collision one segment per clock. Define SNAKE_WRAP_EN for wrapping edges.
module snake_body_ctrl #(
    parameter int MAX_LENGTH = 50,
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        move_tick,
    input  logic [1:0]                  dir,
    input  logic                        grow,
    input  logic                        restart,
    output logic [MAX_LENGTH-1:0][7:0]  body,
    output logic [6:0]                  curr_length,
    output logic [7:0]                  head,
    output logic                        busy,
    output logic                        done,
    output logic                        dead
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DEAD  = 2'd2;

    localparam int         IDXW    = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LENGTH - 1);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [1:0] state_reg;
    logic [1:0] dir_reg;
    logic [1:0] dir_next;
    logic [7:0] body_reg [MAX_LENGTH];
    logic [6:0] len_reg;
    logic [6:0] idx_reg;
    logic       grow_pending_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       dead_reg;

    logic       clear;
    logic       move_req;
    logic       shift_en;
    logic       wall;
    logic       hit;
    logic [3:0] head_x;
    logic [3:0] head_y;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic [7:0] scan_seg;

    function automatic logic [7:0] init_seg(input int i);
        case (i)
            0:       return 8'h44;
            1:       return 8'h34;
            2:       return 8'h24;
            default: return 8'h00;
        endcase
    endfunction

    assign clear    = !nrst || restart;
    assign move_req = (state_reg == IDLE) && move_tick;
    assign shift_en = move_req && !wall;
    assign head_x   = body_reg[0][7:4];
    assign head_y   = body_reg[0][3:0];
    assign scan_seg = body_reg[idx_reg[IDXW-1:0]];
    assign hit      = (scan_seg == body_reg[0]);

    // Reversal requests (up<->down, left<->right differ only in bit 0) are dropped.
    always_comb begin
        dir_next = dir_reg;
        if (dir != (dir_reg ^ 2'b01)) begin
            dir_next = dir;
        end
        cand_x = head_x;
        cand_y = head_y;
        wall   = 1'b0;
        case (dir_next)
            2'b00: begin
                if (head_y == 4'd0) begin
                    if (WRAP_EN) cand_y = Y_MAX;
                    else         wall   = 1'b1;
                end else begin
                    cand_y = head_y - 4'd1;
                end
            end
            2'b01: begin
                if (head_y >= Y_MAX) begin
                    if (WRAP_EN) cand_y = 4'd0;
                    else         wall   = 1'b1;
                end else begin
                    cand_y = head_y + 4'd1;
                end
            end
            2'b10: begin
                if (head_x == 4'd0) begin
                    if (WRAP_EN) cand_x = X_MAX;
                    else         wall   = 1'b1;
                end else begin
                    cand_x = head_x - 4'd1;
                end
            end
            default: begin
                if (head_x >= X_MAX) begin
                    if (WRAP_EN) cand_x = 4'd0;
                    else         wall   = 1'b1;
                end else begin
                    cand_x = head_x + 4'd1;
                end
            end
        endcase
    end

    // Every slot shifts on a legal move; slots past the tail carry don't-care history.
    generate
        for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (clear) begin
                    body_reg[gi] <= init_seg(gi);
                end else if (shift_en) begin
                    if (gi == 0) body_reg[gi] <= {cand_x, cand_y};
                    else         body_reg[gi] <= body_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
            assign body[gi] = body_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg        <= IDLE;
            dir_reg          <= 2'b11;
            len_reg          <= 7'd2;
            idx_reg          <= 7'd1;
            grow_pending_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            dead_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (move_req) begin
                        dir_reg <= dir_next;
                        if (wall) begin
                            dead_reg  <= 1'b1;
                            state_reg <= DEAD;
                        end else begin
                            if ((grow_pending_reg || grow) && (len_reg < LEN_MAX)) begin
                                len_reg <= len_reg + 7'd1;
                            end
                            grow_pending_reg <= 1'b0;
                            idx_reg          <= 7'd1;
                            busy_reg         <= 1'b1;
                            state_reg        <= CHECK;
                        end
                    end else if (grow) begin
                        grow_pending_reg <= 1'b1;
                    end
                end
                CHECK: begin
                    if (grow) grow_pending_reg <= 1'b1;
                    if (hit) begin
                        dead_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DEAD;
                    end else if (idx_reg == len_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        idx_reg <= idx_reg + 7'd1;
                    end
                end
                DEAD: begin
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign head        = body_reg[0];
    assign curr_length = len_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign dead        = dead_reg;

endmodule
